// File: rtl/mux2_4_arb.sv
// mux2_4_arb: upstream feeder for a WIDTH-bit 2:1 mux (res = S ? in1 : in0).
//
// Two valid/ready source channels (A, B) each load a one-word holding
// register. A two-state arbiter presents one full register at a time to the
// consumer over out_valid/out_ready. Ties are granted round-robin.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   a_valid/a_data/a_ready  channel A source handshake
//   b_valid/b_data/b_ready  channel B source handshake
//   in0, in1             holding registers A and B, to mux inputs
//   S                    mux select (0 = A, 1 = B)
//   out_valid/out_ready  consumer handshake for res
//   cnt_a, cnt_b         saturating per-channel transfer counters
//                        (only when MUX2_4_ARB_STATS_EN is defined)
//
// Optional feature macro: MUX2_4_ARB_STATS_EN

// One-word holding register for a single source channel.
module mux2_4_arb_hold #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld,
  input  logic [WIDTH-1:0] data,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  // Load only when empty; clear only happens when full, so the two never
  // collide. No bypass: a cleared register refills one cycle later earliest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      full <= 1'b0;
    end else if (vld && !full) begin
      q    <= data;
      full <= 1'b1;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

module mux2_4_arb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic [WIDTH-1:0] in0,
  output logic [WIDTH-1:0] in1,
  output logic             S,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX2_4_ARB_STATS_EN
  ,
  output logic [7:0]       cnt_a,
  output logic [7:0]       cnt_b
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] data;
  } chan_req_t;

  // Channel index 0 = A, 1 = B; S indexes these arrays directly.
  chan_req_t [1:0]            req;
  logic      [1:0]            full;
  logic      [1:0]            clr;
  logic      [1:0][WIDTH-1:0] q;

  state_t state, state_nxt;
  logic   sel, sel_nxt;
  logic   last_grant, last_grant_nxt;  // 0 = A, 1 = B
  logic   xfer;

  assign req[0] = '{vld: a_valid, data: a_data};
  assign req[1] = '{vld: b_valid, data: b_data};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_ch
      mux2_4_arb_hold #(.WIDTH(WIDTH)) u_hold (
        .clk  (clk),
        .rst_n(rst_n),
        .vld  (req[g].vld),
        .data (req[g].data),
        .clr  (clr[g]),
        .q    (q[g]),
        .full (full[g])
      );
    end
  endgenerate

  assign a_ready   = ~full[0];
  assign b_ready   = ~full[1];
  assign in0       = q[0];
  assign in1       = q[1];
  assign S         = sel;
  assign out_valid = (state == SEND);
  assign xfer      = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;  // B, so A wins the first tie
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    clr            = '0;
    case (state)
      IDLE: begin
        if (|full) begin
          state_nxt = SEND;
          // Tie goes to the channel not granted last; otherwise the full one.
          sel_nxt   = (&full) ? ~last_grant : full[1];
        end
      end
      SEND: begin
        if (out_ready) begin
          clr[sel]       = 1'b1;
          last_grant_nxt = sel;
          // Other channel already waiting: switch without an IDLE bubble.
          if (full[~sel]) sel_nxt   = ~sel;
          else            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MUX2_4_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (xfer) begin
      if (!sel && cnt_a != 8'hFF) cnt_a <= cnt_a + 8'd1;
      if ( sel && cnt_b != 8'hFF) cnt_b <= cnt_b + 8'd1;
    end
  end
`endif

endmodule
